jtframe_rst_seq: RTL and testbench

JTFRAME_RST_SEQ -- requirements
Module: jtframe_rst_seq

---
 rtl/jtframe_rst_seq.sv | 93 +++++++++
 tb/tb_jtframe_rst_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rst_seq.sv
// Power-up reset sequencer: waits for a stable PLL lock, then releases
// CHANNELS reset domains one after another, STAGE clock cycles apart.
module jtframe_rst_seq #(
    parameter int CHANNELS = 4,
    parameter int STAGE    = 16,
    parameter int LOCKW    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                locked,
    input  logic                soft_rst,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready,
    output logic                lock_lost
);
    localparam int MAXC = (LOCKW > STAGE) ? LOCKW : STAGE;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = $clog2(CHANNELS) + 1;

    localparam logic [CW-1:0] LOCK_END  = CW'(LOCKW - 1);
    localparam logic [CW-1:0] STAGE_END = CW'(STAGE - 1);
    localparam logic [IW-1:0] LAST      = IW'(CHANNELS - 1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RELEASE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          locked_m, locked_s;

    // locked comes straight from the PLL, so it is resynchronised first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            idx       <= '0;
            rst_out   <= '1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else if (state == WAIT_LOCK) begin
            rst_out <= '1;
            ready   <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            if (soft_rst) lock_lost <= 1'b0;
            if (locked_s && !soft_rst) state <= SETTLE;
        end else if (!locked_s || soft_rst) begin
            // any disturbance restarts from scratch, including the full settle
            state   <= WAIT_LOCK;
            rst_out <= '1;
            ready   <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            if (!locked_s && (state == RELEASE || state == RUN)) lock_lost <= 1'b1;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt == LOCK_END) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == STAGE_END) begin
                        cnt     <= '0;
                        rst_out <= rst_out & ~(CHANNELS'(1) << idx);
                        idx     <= idx + 1'b1;
                        if (idx == LAST) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_rst_seq.sv
// Bench for jtframe_rst_seq: default instance (4/16/64) and a minimal
// instance (1/1/1) share stimulus and are checked against a timing model.
module tb_jtframe_rst_seq;
    localparam int C0 = 4, S0 = 16, L0 = 64;

    logic       clk = 1'b0, rst_n = 1'b1, locked = 1'b0, soft_rst = 1'b0;
    logic [3:0] rst_a;
    logic       rdy_a, ll_a;
    logic [0:0] rst_b;
    logic       rdy_b, ll_b;

    int checks = 0, errors = 0;

    jtframe_rst_seq #(.CHANNELS(C0), .STAGE(S0), .LOCKW(L0)) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .soft_rst(soft_rst),
        .rst_out(rst_a), .ready(rdy_a), .lock_lost(ll_a)
    );

    jtframe_rst_seq #(.CHANNELS(1), .STAGE(1), .LOCKW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .locked(locked), .soft_rst(soft_rst),
        .rst_out(rst_b), .ready(rdy_b), .lock_lost(ll_b)
    );

    always #5 clk = ~clk;

    // Model: "active" means a sequence is in progress, n = cycles since t0.
    typedef struct {
        bit lm;
        bit ls;
        bit active;
        int n;
        bit ll;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t r;
        r.lm = 0; r.ls = 0; r.active = 0; r.n = 0; r.ll = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input bit lk, input bit sr, input int lw);
        mdl_t r = m;
        r.lm = lk;
        r.ls = m.lm;
        if (!m.active) begin
            if (sr) r.ll = 0;
            if (m.ls && !sr) begin
                r.active = 1;
                r.n = 0;
            end
        end else if (!m.ls || sr) begin
            if (!m.ls && m.n >= lw) r.ll = 1;
            r.active = 0;
            r.n = 0;
        end else if (m.n < 1000000) begin
            r.n = m.n + 1;
        end
        return r;
    endfunction

    function automatic int mrel(input mdl_t m, input int ch, input int lw, input int st);
        int rel;
        if (!m.active || m.n < lw) return 0;
        rel = (m.n - lw) / st;
        return (rel > ch) ? ch : rel;
    endfunction

    function automatic int mrst(input mdl_t m, input int ch, input int lw, input int st);
        int all = (1 << ch) - 1;
        return all & ~((1 << mrel(m, ch, lw, st)) - 1);
    endfunction

    function automatic int mrdy(input mdl_t m, input int ch, input int lw, input int st);
        return (m.active && mrel(m, ch, lw, st) == ch) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        ma = mstep(ma, locked, soft_rst, L0);
        mb = mstep(mb, locked, soft_rst, 1);
        @(negedge clk);
        chk("model_rst_a", {28'b0, rst_a}, mrst(ma, C0, L0, S0));
        chk("model_rdy_a", {31'b0, rdy_a}, mrdy(ma, C0, L0, S0));
        chk("model_ll_a",  {31'b0, ll_a},  {31'b0, ma.ll});
        chk("model_rst_b", {31'b0, rst_b}, mrst(mb, 1, 1, 1));
        chk("model_rdy_b", {31'b0, rdy_b}, mrdy(mb, 1, 1, 1));
        chk("model_ll_b",  {31'b0, ll_b},  {31'b0, mb.ll});
    endtask

    // Called at a negedge; asserts reset mid-cycle and checks before the next edge.
    task automatic apply_reset();
        #1 rst_n = 1'b0;
        ma = mreset();
        mb = mreset();
        #1;
        chk("async_rst_a", {28'b0, rst_a}, 32'hF);
        chk("async_rdy_a", {31'b0, rdy_a}, 32'h0);
        chk("async_ll_a",  {31'b0, ll_a},  32'h0);
        chk("async_rst_b", {31'b0, rst_b}, 32'h1);
        chk("async_ll_b",  {31'b0, ll_b},  32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         lk;
        bit         sr;
        int         n;
        logic [3:0] rst;
        bit         rdy;
        bit         ll;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int lock_hold, soft_hold;
        ma = mreset();
        mb = mreset();

        // power-up, then glitches, soft resets and a relock, all from t0 arithmetic
        tbl.push_back('{1, 0,   2, 4'hF, 0, 0});
        tbl.push_back('{1, 0,   1, 4'hF, 0, 0});
        tbl.push_back('{1, 0,  79, 4'hF, 0, 0});
        tbl.push_back('{1, 0,   1, 4'hE, 0, 0});
        tbl.push_back('{1, 0,  15, 4'hE, 0, 0});
        tbl.push_back('{1, 0,   1, 4'hC, 0, 0});
        tbl.push_back('{1, 0,  16, 4'h8, 0, 0});
        tbl.push_back('{1, 0,  15, 4'h8, 0, 0});
        tbl.push_back('{1, 0,   1, 4'h0, 1, 0});
        tbl.push_back('{1, 1,   1, 4'hF, 0, 0});
        tbl.push_back('{1, 0,   1, 4'hF, 0, 0});
        tbl.push_back('{1, 0,  80, 4'hE, 0, 0});
        tbl.push_back('{1, 0,  48, 4'h0, 1, 0});
        tbl.push_back('{0, 0,   1, 4'h0, 1, 0});
        tbl.push_back('{0, 0,   1, 4'h0, 1, 0});
        tbl.push_back('{0, 0,   1, 4'hF, 0, 1});
        tbl.push_back('{1, 0,   3, 4'hF, 0, 1});
        tbl.push_back('{1, 0, 128, 4'h0, 1, 1});
        tbl.push_back('{1, 1,   1, 4'hF, 0, 1});
        tbl.push_back('{1, 1,   1, 4'hF, 0, 0});
        tbl.push_back('{1, 0,   1, 4'hF, 0, 0});
        tbl.push_back('{1, 0,  30, 4'hF, 0, 0});
        tbl.push_back('{0, 0,   3, 4'hF, 0, 0});
        tbl.push_back('{1, 0,   3, 4'hF, 0, 0});
        tbl.push_back('{1, 0,  79, 4'hF, 0, 0});
        tbl.push_back('{1, 0,   1, 4'hE, 0, 0});

        @(negedge clk);
        apply_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            locked   = tbl[i].lk;
            soft_rst = tbl[i].sr;
            repeat (tbl[i].n) cycle();
            chk($sformatf("vec%0d_rst", i), {28'b0, rst_a}, {28'b0, tbl[i].rst});
            chk($sformatf("vec%0d_rdy", i), {31'b0, rdy_a}, {31'b0, tbl[i].rdy});
            chk($sformatf("vec%0d_ll", i),  {31'b0, ll_a},  {31'b0, tbl[i].ll});
        end

        // lock lost in RELEASE, re-sequence to 4'hC, then async reset mid-release
        locked = 1'b0;
        repeat (3) cycle();
        chk("rel_drop_ll", {31'b0, ll_a}, 32'h1);
        locked = 1'b1;
        repeat (3 + 96) cycle();
        chk("resq_rst_c", {28'b0, rst_a}, 32'hC);
        chk("resq_ll", {31'b0, ll_a}, 32'h1);
        apply_reset();

        // minimal instance: release at t0+2, then simultaneous lock drop and soft reset
        locked = 1'b1;
        repeat (4) cycle();
        chk("min_rst_t1", {31'b0, rst_b}, 32'h1);
        cycle();
        chk("min_rst_t2", {31'b0, rst_b}, 32'h0);
        chk("min_rdy_t2", {31'b0, rdy_b}, 32'h1);
        locked = 1'b0;
        repeat (2) cycle();
        chk("min_run_rdy", {31'b0, rdy_b}, 32'h1);
        soft_rst = 1'b1;
        cycle();
        chk("min_both_ll", {31'b0, ll_b}, 32'h1);
        chk("min_both_rst", {31'b0, rst_b}, 32'h1);
        chk("min_both_rdy", {31'b0, rdy_b}, 32'h0);
        soft_rst = 1'b0;
        locked = 1'b1;
        cycle();
        chk("min_ll_held", {31'b0, ll_b}, 32'h1);

        // randomized traffic against the model
        lock_hold = 0;
        soft_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (lock_hold > 0) begin
                lock_hold--;
                locked = 1'b0;
            end else begin
                locked = 1'b1;
                if ($urandom_range(0, 249) == 0) lock_hold = $urandom_range(1, 6);
            end
            if (soft_hold > 0) begin
                soft_hold--;
                soft_rst = 1'b1;
            end else begin
                soft_rst = 1'b0;
                if ($urandom_range(0, 299) == 0) soft_hold = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 999) == 0) apply_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end
endmodule
